// File: rtl/display_pkg.sv
// Shared constants for the score display: segment patterns (active-low, {g,f,e,d,c,b,a}),
// the conversion FSM states and the largest value the six digits can show.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam int unsigned DISPLAY_MAX = 999999;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; purely combinational, no backpressure.
// A set blank input, or an unreachable code above 9, turns every segment off.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// Binary score to six saturating seven-segment digits via a bit-serial double-dabble engine.
// Latency SCORE_W+2 clocks from a score change; no backpressure, later changes are picked up once idle.
module score_display
  import display_pkg::*;
#(
  parameter int SCORE_W       = 24,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5,
  output logic               busy,
  output logic               sat
);

  localparam int BCD_W = 32;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = 5;
  localparam logic [6:0] SEG_RST_HI = BLANK_LEADING ? SEG_BLANK : SEG_0;

  state_t                 state_q, state_d;
  logic [SCORE_W-1:0]     shadow_q, shadow_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   sat_q, sat_d;
  logic [5:0][6:0]        hex_q, hex_d;

  logic [BCD_W-1:0]       bcd;
  logic [BCD_W-1:0]       bcd_adj;
  logic                   over;
  logic                   lead;
  logic [5:0][3:0]        disp_dig;
  logic [5:0]             blank;
  logic [5:0][6:0]        seg;

  assign bcd = sr_q[SR_W-1 -: BCD_W];

  // Add-3 correction applied before each shift keeps every nibble a valid decimal digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    over     = |bcd[BCD_W-1:24];
    disp_dig = '0;
    blank    = '0;
    lead     = BLANK_LEADING && !over;
    for (int i = 0; i < 6; i++) begin
      disp_dig[i] = over ? 4'd9 : bcd[4*i +: 4];
    end
    for (int i = 5; i >= 1; i--) begin
      lead     = lead && (disp_dig[i] == 4'd0);
      blank[i] = lead;
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_dig
    seg7_decode u_dec (
      .digit_i (disp_dig[g]),
      .blank_i (blank[g]),
      .seg_o   (seg[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    sat_d    = sat_q;
    hex_d    = hex_q;
    case (state_q)
      IDLE: begin
        if (score != shadow_q) begin
          shadow_d = score;
          sr_d     = {{BCD_W{1'b0}}, score};
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = {bcd_adj[BCD_W-2:0], sr_q[SCORE_W-1:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = LOAD;
      end
      LOAD: begin
        hex_d   = seg;
        sat_d   = over;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      hex_q    <= {SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_RST_HI, SEG_0};
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
      hex_q    <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign busy = busy_q;
  assign sat  = sat_q;

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the 24-bit binary `score` produced by the mole/scoring stage.
- Converts the score to BCD with a sequential double-dabble engine, one bit per clock.
- Saturates the displayed value at 999999.
- Drives six active-low seven-segment digits (hex0 = least significant) with leading-zero blanking, plus status flags.

Parameters:
- SCORE_W, 24, binary score width; the engine runs SCORE_W iterations per conversion.
- BLANK_LEADING, 1, 1 = blank leading zero digits (hex0 is never blanked); 0 = show all zeros.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- score  input  SCORE_W  binary score from the scoring stage; may change on any cycle
- hex0..hex5  output  7 each  segment patterns, active-low, bit order {g,f,e,d,c,b,a}
- busy  output  1  high while a conversion is in flight
- sat  output  1  high when the displayed value is clamped at 999999

Behaviour:
- Reset (asynchronous, active-high) values:
  - hex0 = 7'h40 (digit 0).
  - hex1..hex5 = 7'h7F (blank) when BLANK_LEADING = 1; 7'h40 otherwise.
  - busy = 0, sat = 0, state = IDLE.
  - shadow score register = 0, so no conversion starts after reset while score = 0.
- States: IDLE, CONVERT, LOAD.
- IDLE:
  - At posedge k, if score != shadow: shadow <= score; shift register <= {32'b0, score}; iteration counter <= 0; busy <= 1; go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT:
  - Each cycle, every 4-bit BCD nibble (8 nibbles, 32 bits) that is >= 5 gets +3.
  - Then the combined {bcd, bin} register shifts left by 1.
  - After SCORE_W iterations (posedges k+1 .. k+SCORE_W), go to LOAD.
- LOAD (posedge k+SCORE_W+1):
  - If BCD digit 7 or digit 6 is nonzero: all six digits become 9 and sat <= 1.
  - Otherwise the low six digits are used and sat <= 0.
  - Digits are decoded to segments; hex registers are updated; busy <= 0; go to IDLE.
- Latency:
  - With the default width, outputs reflect a score sampled at posedge k after posedge k+25.
  - busy is high from after posedge k through after posedge k+24.
  - hex and sat change only in LOAD, so they never glitch through intermediate values.
- Score change during CONVERT:
  - The conversion in flight completes with its captured value and is shown.
  - IDLE then sees score != shadow and restarts.
  - The final display always converges to the latest stable score.
  - No score value is lost while score stays stable for at least SCORE_W + 2 cycles.
- Leading-zero blanking (BLANK_LEADING = 1):
  - Digit i (i >= 1) is blanked (7'h7F) iff it and all higher displayed digits are 0.
  - When sat = 1, no digits are blanked.
- Decode table for digits 0-9, active-low: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10. Digit codes above 9 are unreachable; they decode to 7'h7F.
- Reset asserted mid-conversion: immediately returns to the reset values. After release, a nonzero score triggers a fresh conversion from IDLE.
- Width and arithmetic:
  - The BCD field is 32 bits (8 digits), which covers 2^24 - 1 = 16777215.
  - The iteration counter is 5 bits.
  - No arithmetic wraps.

Decomposition:
- Shared package `display_pkg` holds:
  - SEG_BLANK = 7'h7F.
  - The ten digit segment constants.
  - The state enum {IDLE, CONVERT, LOAD}.
  - The DISPLAY_MAX = 999999 constant.
- One sub-module `seg7_decode`: combinational, 4-bit digit plus blank input -> 7-bit active-low pattern. It is instantiated six times.

Test Plan:
- Reset, then release with score = 0 for 100 cycles -> hex0 = 40, hex1..hex5 = 7F, busy stays 0, sat = 0.
- score 0 -> 24414 at posedge k -> busy high for cycles k+1..k+25; after k+25: hex4..hex0 = 24,19,19,79,19 (24414), hex5 = 7F, sat = 0.
- score = 1000000 -> all hex = 10 (999999), sat = 1. Then score = 16777215 -> unchanged 999999, sat = 1.
- score = 123 at k, then 456789 at k+5 -> first the display shows 123 (hex2..hex0 = 79,24,30); then after a second conversion it shows 456789 (19,12,02,78,00,10) with no blanking.
- rst pulsed (asynchronously, mid-cycle) at k+10 of a conversion of 999 -> outputs take reset values immediately. After release with score still 999, display shows 10,10,10 on hex2..hex0 after 26 cycles.
- BLANK_LEADING = 0 with score = 7 -> hex5..hex1 = 40, hex0 = 78.
